// File: rtl/scratch_fetch.sv
// scratch_fetch: responder side of the pixel-selection interface.
//
// Takes one pixel request (row, column, width, offset, zero) per load_en handshake, forms the
// linear scratchpad address offset + row*width + column (mod 2^ADDR_W), reads it through a
// request/accept/valid memory port and returns the pixel with a one-cycle scratch_rdy pulse.
// Zero requests skip the memory entirely and return 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   row, column, width    pixel coordinates and row stride of the current buffer
//   offset                base address of the current buffer
//   zero                  request returns 0 without a memory access; also forces pixel_out to 0
//   load_en               request valid (level)
//   scratch_rdy           one-cycle pulse per served request
//   pixel_out             returned pixel (0 while zero=1)
//   busy                  high whenever the engine is not idle
//   mem_r_en / mem_addr   read request and its address (address holds while no request)
//   mem_r_accept          memory takes the request this cycle
//   mem_r_valid/mem_r_data  read data return
module scratch_fetch #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  row,
    input  logic [DIM_W-1:0]  column,
    input  logic [DIM_W-1:0]  width,
    input  logic [ADDR_W-1:0] offset,
    input  logic              zero,
    input  logic              load_en,
    output logic              scratch_rdy,
    output logic [DATA_W-1:0] pixel_out,
    output logic              busy,
    output logic              mem_r_en,
    input  logic              mem_r_accept,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam int unsigned ProdW = 2 * DIM_W;
    localparam int unsigned SumW  = ((ProdW > ADDR_W) ? ProdW : ADDR_W) + 2;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait,
        StReady
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              rdy_q, rdy_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;

    logic [ProdW-1:0]  prod;
    logic [ADDR_W-1:0] lin_addr;

    // Product kept at full 2*DIM_W width; the sum is widened so nothing is lost before the
    // final modulo-2^ADDR_W truncation.
    always_comb begin
        prod     = ProdW'(row) * ProdW'(width);
        lin_addr = ADDR_W'(SumW'(offset) + SumW'(prod) + SumW'(column));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pix_d   = pix_q;

        unique case (state_q)
            StIdle: begin
                if (load_en) begin
                    if (zero) begin
                        pix_d   = '0;
                        state_d = StReady;
                    end else begin
                        addr_d  = lin_addr;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                // Read data cannot arrive before the accept, so mem_r_valid is not looked at.
                if (mem_r_accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_r_valid) begin
                    // Data is captured even when the request was withdrawn; only the pulse is
                    // suppressed.
                    pix_d   = mem_r_data;
                    state_d = load_en ? StReady : StIdle;
                end
            end
            StReady: begin
                // Always pass through idle so a request is never served twice.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        rdy_d  = (state_d == StReady);
        en_d   = (state_d == StAddr);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pix_q   <= '0;
            rdy_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            rdy_q   <= rdy_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign scratch_rdy = rdy_q;
    assign mem_r_en    = en_q;
    assign busy        = busy_q;
    assign mem_addr    = addr_q;
    // Padding shifts in the controller read 0 here without any handshake.
    assign pixel_out   = zero ? '0 : pix_q;

endmodule

// File: tb/tb_scratch_fetch.sv
module tb_scratch_fetch;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 20;
    localparam int unsigned DMW = 12;

    logic           clk;
    logic           rst_n;
    logic [DMW-1:0] row, column, width;
    logic [AW-1:0]  offset;
    logic           zero, load_en;
    logic           scratch_rdy;
    logic [DW-1:0]  pixel_out;
    logic           busy, mem_r_en;
    logic           mem_r_accept;
    logic [AW-1:0]  mem_addr;
    logic           mem_r_valid;
    logic [DW-1:0]  mem_r_data;

    int checks = 0;
    int errors = 0;

    scratch_fetch #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DIM_W (DMW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .column      (column),
        .width       (width),
        .offset      (offset),
        .zero        (zero),
        .load_en     (load_en),
        .scratch_rdy (scratch_rdy),
        .pixel_out   (pixel_out),
        .busy        (busy),
        .mem_r_en    (mem_r_en),
        .mem_r_accept(mem_r_accept),
        .mem_addr    (mem_addr),
        .mem_r_valid (mem_r_valid),
        .mem_r_data  (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accepts after acc_dly_cfg stalled cycles, returns mem_byte lat_cfg cycles
    // after the accept. Keeps running through reset so stale returns can be observed.
    int            acc_dly_cfg = 0;
    int            lat_cfg     = 1;
    logic [DW-1:0] mem_byte    = '0;
    int            en_total    = 0;
    int            acc_total   = 0;
    int            stab_err    = 0;
    logic [AW-1:0] addr_log[$];

    initial begin
        int            en_run;
        int            pend_cd;
        logic          prev_en;
        logic [AW-1:0] prev_addr;
        en_run       = 0;
        pend_cd      = 0;
        prev_en      = 1'b0;
        prev_addr    = '0;
        mem_r_accept = 1'b0;
        mem_r_valid  = 1'b0;
        mem_r_data   = '0;
        forever begin
            @(negedge clk);
            mem_r_accept = 1'b0;
            mem_r_valid  = 1'b0;
            mem_r_data   = DW'($urandom);
            if (pend_cd > 0) begin
                pend_cd--;
                if (pend_cd == 0) begin
                    mem_r_valid = 1'b1;
                    mem_r_data  = mem_byte;
                end
            end
            if (mem_r_en === 1'b1) begin
                en_total++;
                if (prev_en && mem_addr !== prev_addr) stab_err++;
                if (en_run >= acc_dly_cfg) begin
                    mem_r_accept = 1'b1;
                    en_run       = 0;
                    pend_cd      = lat_cfg;
                    acc_total++;
                    addr_log.push_back(mem_addr);
                end else begin
                    en_run++;
                end
            end else begin
                en_run = 0;
            end
            prev_en   = (mem_r_en === 1'b1);
            prev_addr = mem_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference address: plain integer arithmetic, reduced modulo 2^AW.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] o, input logic [DMW-1:0] r,
                                               input logic [DMW-1:0] c, input logic [DMW-1:0] w);
        longint unsigned lo, lr, lc, lw, full;
        lo   = o;
        lr   = r;
        lc   = c;
        lw   = w;
        full = lo + lr * lw + lc;
        return AW'(full % (64'd1 << AW));
    endfunction

    // Drives one request from a negedge and follows it until the DUT has been idle a while.
    task automatic issue(input logic [DMW-1:0] r, input logic [DMW-1:0] c,
                         input logic [DMW-1:0] w, input logic [AW-1:0] o, input logic z,
                         input bit abort, output int rdy_at, output int rdy_cnt,
                         output logic [DW-1:0] pix_at_rdy);
        int idle_run;
        row        = r;
        column     = c;
        width      = w;
        offset     = o;
        zero       = z;
        load_en    = 1'b1;
        rdy_at     = -1;
        rdy_cnt    = 0;
        pix_at_rdy = '0;
        idle_run   = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (scratch_rdy === 1'b1) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at     = n;
                    pix_at_rdy = pixel_out;
                end
                load_en = 1'b0;
            end else if (abort && load_en && busy === 1'b1 && mem_r_en === 1'b0) begin
                load_en = 1'b0;
            end
            if (!load_en && busy === 1'b0) idle_run++;
            else idle_run = 0;
            if (idle_run >= 3) break;
        end
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (scratch_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", scratch_rdy); end
        checks++; if (mem_r_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", mem_r_en); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pixel_out !== '0) begin errors++; $display("FAIL reset_pixel: got %h expected 0", pixel_out); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int at, cnt, en0, base;
        logic [DW-1:0] pix;
        acc_dly_cfg = 0;
        lat_cfg     = 1;
        mem_byte    = 8'hA5;
        en0         = en_total;
        base        = addr_log.size();
        issue(12'd2, 12'd3, 12'd5, 20'h00100, 1'b0, 1'b0, at, cnt, pix);
        checks++; if (at !== 3) begin errors++; $display("FAIL basic_rdy_at: got %0d expected 3", at); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL basic_rdy_cnt: got %0d expected 1", cnt); end
        checks++; if (pix !== 8'hA5) begin errors++; $display("FAIL basic_pixel: got %h expected a5", pix); end
        checks++; if (en_total - en0 !== 1) begin errors++; $display("FAIL basic_en_cycles: got %0d expected 1", en_total - en0); end
        checks++;
        if (addr_log.size() != base + 1 || addr_log[base] !== 20'h0010D) begin
            errors++; $display("FAIL basic_addr: got %h expected 0010d", mem_addr);
        end
        checks++; if (pixel_out !== 8'hA5) begin errors++; $display("FAIL basic_pixel_hold: got %h expected a5", pixel_out); end
    endtask

    task automatic test_zero();
        int at, cnt, en0;
        logic [DW-1:0] pix;
        en0 = en_total;
        issue(12'd7, 12'd9, 12'd11, 20'h01234, 1'b1, 1'b0, at, cnt, pix);
        checks++; if (at !== 1) begin errors++; $display("FAIL zero_rdy_at: got %0d expected 1", at); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL zero_rdy_cnt: got %0d expected 1", cnt); end
        checks++; if (pix !== '0) begin errors++; $display("FAIL zero_pixel: got %h expected 0", pix); end
        checks++; if (en_total !== en0) begin errors++; $display("FAIL zero_no_mem: got %0d expected %0d", en_total, en0); end
        zero = 1'b0;
        #1;
        checks++; if (pixel_out !== '0) begin errors++; $display("FAIL zero_reg_cleared: got %h expected 0", pixel_out); end
    endtask

    task automatic test_stall();
        int at, cnt, en0, st0, base;
        logic [DW-1:0] pix;
        logic [DMW-1:0] r, c, w;
        logic [AW-1:0] o;
        r = DMW'($urandom); c = DMW'($urandom); w = DMW'($urandom); o = AW'($urandom);
        acc_dly_cfg = 4;
        lat_cfg     = 2;
        mem_byte    = DW'($urandom);
        en0  = en_total;
        st0  = stab_err;
        base = addr_log.size();
        issue(r, c, w, o, 1'b0, 1'b0, at, cnt, pix);
        checks++; if (en_total - en0 !== 5) begin errors++; $display("FAIL stall_en_cycles: got %0d expected 5", en_total - en0); end
        checks++; if (stab_err !== st0) begin errors++; $display("FAIL stall_addr_stable: got %0d changes expected 0", stab_err - st0); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL stall_rdy_cnt: got %0d expected 1", cnt); end
        checks++; if (at !== 4 + 2 + 2) begin errors++; $display("FAIL stall_rdy_at: got %0d expected 8", at); end
        checks++; if (pix !== mem_byte) begin errors++; $display("FAIL stall_pixel: got %h expected %h", pix, mem_byte); end
        checks++;
        if (addr_log.size() != base + 1 || addr_log[base] !== exp_addr(o, r, c, w)) begin
            errors++; $display("FAIL stall_addr: got %h expected %h", mem_addr, exp_addr(o, r, c, w));
        end
        acc_dly_cfg = 0;
    endtask

    task automatic test_abort();
        int at, cnt, a0;
        logic [DW-1:0] pix;
        acc_dly_cfg = 0;
        lat_cfg     = 3;
        mem_byte    = 8'h5E;
        a0 = acc_total;
        issue(12'd4, 12'd1, 12'd8, 20'h00040, 1'b0, 1'b1, at, cnt, pix);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL abort_no_rdy: got %0d pulses expected 0", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (acc_total - a0 !== 1) begin errors++; $display("FAIL abort_accepts: got %0d expected 1", acc_total - a0); end
        checks++; if (pixel_out !== 8'h5E) begin errors++; $display("FAIL abort_captured: got %h expected 5e", pixel_out); end
        lat_cfg = 1;
    endtask

    task automatic test_reset_mid_fetch();
        bit seen;
        int rdy, bz;
        acc_dly_cfg = 0;
        lat_cfg     = 3;
        mem_byte    = 8'hC3;
        row = 12'd3; column = 12'd2; width = 12'd10; offset = 20'h00200; zero = 1'b0;
        load_en = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_r_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_fetch_started: got 0 expected 1"); end
        @(negedge clk);
        load_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", mem_addr); end
        checks++; if (pixel_out !== '0) begin errors++; $display("FAIL midrst_pixel: got %h expected 0", pixel_out); end
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 0;
        bz  = 0;
        repeat (6) begin
            @(negedge clk);
            if (scratch_rdy !== 1'b0) rdy++;
            if (busy !== 1'b0) bz++;
        end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL midrst_stale_rdy: got %0d pulses expected 0", rdy); end
        checks++; if (bz !== 0) begin errors++; $display("FAIL midrst_stays_idle: got %0d busy cycles expected 0", bz); end
        checks++; if (pixel_out !== '0) begin errors++; $display("FAIL midrst_stale_pixel: got %h expected 0", pixel_out); end
        lat_cfg = 1;
    endtask

    task automatic test_wrap();
        int at, cnt, base;
        logic [DW-1:0] pix;
        acc_dly_cfg = 0;
        lat_cfg     = 1;
        mem_byte    = 8'h77;
        base = addr_log.size();
        issue(12'd1, 12'd0, 12'd4, 20'hFFFFE, 1'b0, 1'b0, at, cnt, pix);
        checks++;
        if (addr_log.size() != base + 1 || addr_log[base] !== 20'h00002) begin
            errors++; $display("FAIL wrap_addr: got %h expected 00002", mem_addr);
        end
        checks++; if (cnt !== 1 || pix !== 8'h77) begin errors++; $display("FAIL wrap_result: got %0d/%h expected 1/77", cnt, pix); end
    endtask

    task automatic test_random();
        int at, cnt, en0, base, exp_at;
        logic [DW-1:0] pix, exp_pix;
        logic [DMW-1:0] r, c, w;
        logic [AW-1:0] o;
        logic z;
        for (int i = 0; i < 10; i++) begin
            r = DMW'($urandom); c = DMW'($urandom); w = DMW'($urandom); o = AW'($urandom);
            z = ($urandom_range(0, 3) == 0);
            acc_dly_cfg = $urandom_range(0, 3);
            lat_cfg     = $urandom_range(1, 3);
            mem_byte    = DW'($urandom);
            en0  = en_total;
            base = addr_log.size();
            exp_at  = z ? 1 : acc_dly_cfg + lat_cfg + 2;
            exp_pix = z ? '0 : mem_byte;
            issue(r, c, w, o, z, 1'b0, at, cnt, pix);
            checks++;
            if (at !== exp_at || cnt !== 1 || pix !== exp_pix) begin
                errors++;
                $display("FAIL rand%0d_result: got at=%0d cnt=%0d pix=%h expected at=%0d cnt=1 pix=%h",
                         i, at, cnt, pix, exp_at, exp_pix);
            end
            checks++;
            if (z) begin
                if (en_total !== en0) begin
                    errors++; $display("FAIL rand%0d_zero_mem: got %0d expected 0", i, en_total - en0);
                end
            end else if (addr_log.size() != base + 1 || addr_log[base] !== exp_addr(o, r, c, w)) begin
                errors++; $display("FAIL rand%0d_addr: got %h expected %h", i, mem_addr, exp_addr(o, r, c, w));
            end
        end
        zero        = 1'b0;
        acc_dly_cfg = 0;
        lat_cfg     = 1;
    endtask

    task automatic test_back_to_back();
        int pulses, viol, base, bad_pix;
        bit prev_rdy;
        logic [DMW-1:0] r, w, c0;
        logic [AW-1:0] o, e;
        r  = DMW'($urandom);
        w  = DMW'($urandom);
        c0 = DMW'($urandom_range(0, 4000));
        o  = AW'($urandom);
        acc_dly_cfg = $urandom_range(0, 2);
        lat_cfg     = $urandom_range(1, 3);
        mem_byte    = DW'($urandom);
        base     = addr_log.size();
        pulses   = 0;
        viol     = 0;
        bad_pix  = 0;
        prev_rdy = 1'b0;
        row = r; width = w; offset = o; column = c0; zero = 1'b0;
        load_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (prev_rdy && busy !== 1'b0) viol++;
            prev_rdy = (scratch_rdy === 1'b1);
            if (scratch_rdy === 1'b1) begin
                if (pixel_out !== mem_byte) bad_pix++;
                pulses++;
                mem_byte = DW'($urandom);
                if (pulses >= 16) load_en = 1'b0;
                else column = column + 1'b1;
            end
            if (!load_en && busy === 1'b0 && !prev_rdy) break;
        end
        load_en = 1'b0;
        checks++; if (pulses !== 16) begin errors++; $display("FAIL b2b_pulses: got %0d expected 16", pulses); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_idle_gap: got %0d violations expected 0", viol); end
        checks++; if (bad_pix !== 0) begin errors++; $display("FAIL b2b_pixels: got %0d wrong expected 0", bad_pix); end
        checks++;
        if (addr_log.size() != base + 16) begin
            errors++; $display("FAIL b2b_fetch_count: got %0d expected 16", addr_log.size() - base);
        end
        for (int i = 0; i < 16 && base + i < addr_log.size(); i++) begin
            e = exp_addr(o, r, DMW'(c0 + DMW'(i)), w);
            checks++;
            if (addr_log[base + i] !== e) begin
                errors++; $display("FAIL b2b_addr%0d: got %h expected %h", i, addr_log[base + i], e);
            end
        end
        acc_dly_cfg = 0;
        lat_cfg     = 1;
    endtask

    initial begin
        row = '0; column = '0; width = '0; offset = '0; zero = 1'b0; load_en = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_abort();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
